// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: one request/ack bus (client side or SDRAM port1 side).
// The master drives the command fields and req; the slave returns q and ack.
interface sdram_arbiter_if #(
   parameter int AW = 24
) ();
   logic          req;
   logic          we;
   logic [AW:1]   a;
   logic [1:0]    ds;
   logic [15:0]   d;
   logic [15:0]   q;
   logic          ack;

   modport master (output req, we, a, ds, d, input q, ack);
   modport slave  (input req, we, a, ds, d, output q, ack);
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter of two level-request clients onto the toggle-handshake port1.
// Define SDRAM_ARB_RDCACHE_EN to add a one-entry read cache in front of client 1.
module sdram_arbiter #(
   parameter int AW = 24
) (
   input  logic            clk,
   input  logic            reset,
   sdram_arbiter_if.slave  c0,
   sdram_arbiter_if.slave  c1,
   sdram_arbiter_if.master port1
);

   typedef enum logic [1:0] {IDLE, WAIT, RECOVER} state_t;

   state_t        state, state_next;
   logic          last;
   logic          gnt;
   logic          g_sel;
   logic          grant;
   logic          issue;
   logic          complete;
   logic          lookup_hit;
   logic          txn_rd;
   logic          sel_we;
   logic [AW:1]   sel_a;
   logic [1:0]    sel_ds;
   logic [15:0]   sel_d;
   logic [15:0]   rd_data;

   // A lone requester wins; on a tie the client not served last wins.
   assign g_sel  = (c0.req && c1.req) ? ~last : c1.req;
   assign sel_we = g_sel ? c1.we : c0.we;
   assign sel_a  = g_sel ? c1.a  : c0.a;
   assign sel_ds = g_sel ? c1.ds : c0.ds;
   assign sel_d  = g_sel ? c1.d  : c0.d;

`ifdef SDRAM_ARB_RDCACHE_EN
   logic          cache_valid;
   logic          hit_pend;
   logic          fill;
   logic [AW:1]   cache_addr;
   logic [15:0]   cache_data;

   assign lookup_hit = g_sel && !c1.we && (c1.ds == 2'b11) && cache_valid && (cache_addr == c1.a);
   assign fill       = complete && !hit_pend && gnt && !port1.we && (port1.ds == 2'b11);
   assign rd_data    = hit_pend ? cache_data : port1.q;
   assign txn_rd     = hit_pend || !port1.we;

   // A hit parks in WAIT without toggling port1_req, so req==ack already holds and it completes next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cache_valid <= 1'b0;
         hit_pend    <= 1'b0;
      end else begin
         if (grant)
            hit_pend <= lookup_hit;
         if (grant && sel_we && (sel_a == cache_addr))
            cache_valid <= 1'b0;
         else if (fill)
            cache_valid <= 1'b1;
      end
   end

   // NOTE: the cached address/data need no reset; cache_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (fill) begin
         cache_addr <= port1.a;
         cache_data <= port1.q;
      end
   end
`else
   assign lookup_hit = 1'b0;
   assign rd_data    = port1.q;
   assign txn_rd     = !port1.we;
`endif

   // NOTE: every signal is given a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      issue      = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (c0.req || c1.req) begin
               grant      = 1'b1;
               issue      = !lookup_hit;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (port1.ack == port1.req) begin
               complete   = 1'b1;
               state_next = RECOVER;
            end
         end
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         gnt       <= 1'b0;
         port1.req <= port1.ack;
         port1.we  <= 1'b0;
         port1.a   <= '0;
         port1.ds  <= '0;
         port1.d   <= '0;
         c0.q      <= '0;
         c1.q      <= '0;
         c0.ack    <= 1'b0;
         c1.ack    <= 1'b0;
      end else begin
         state  <= state_next;
         c0.ack <= complete && !gnt;
         c1.ack <= complete && gnt;
         if (grant) begin
            last <= g_sel;
            gnt  <= g_sel;
         end
         if (issue) begin
            port1.req <= ~port1.req;
            port1.we  <= sel_we;
            port1.a   <= sel_a;
            port1.ds  <= sel_ds;
            port1.d   <= sel_d;
         end
         if (complete && txn_rd) begin
            if (gnt)
               c1.q <= rd_data;
            else
               c0.q <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with a toggle-handshake SDRAM controller model on port1.
// Exercises the SDRAM_ARB_RDCACHE_EN cache when that macro is defined.
`timescale 1ns/1ps
module tb_sdram_arbiter;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.AW(AW)) c0 ();
   sdram_arbiter_if #(.AW(AW)) c1 ();
   sdram_arbiter_if #(.AW(AW)) port1 ();

   sdram_arbiter #(.AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .c0    (c0),
      .c1    (c1),
      .port1 (port1)
   );

   typedef struct packed {
      logic        client;
      logic [15:0] q;
   } exp_t;

   typedef struct packed {
      logic        we;
      logic [AW:1] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } txn_t;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   exp_t        obs, exp_e;
   logic [15:0] q_model [2];
   int          ack_cnt [2];
   int          toggles = 0;
   logic        prev_req;

   // ---------------- controller model ----------------
   logic [15:0] mem [int];
   txn_t        txn_log[$];
   txn_t        cur;
   bit          model_init = 1'b0;
   logic        busy = 1'b0;
   logic        unstable = 1'b0;
   int          lat_left = 0;
   int          latency = 6;

   function automatic logic [15:0] mem_rd(input logic [AW:1] a);
      if (mem.exists(int'(a)))
         return mem[int'(a)];
      return 16'h0000;
   endfunction

   always @(posedge clk) begin
      logic [15:0] old;
      logic        moved;
      if (!model_init) begin
         port1.ack  <= 1'b0;
         port1.q    <= '0;
         model_init <= 1'b1;
      end else if (!busy) begin
         if (!reset && (port1.req !== port1.ack)) begin
            busy     <= 1'b1;
            lat_left <= latency;
            unstable <= 1'b0;
            cur      <= {port1.we, port1.a, port1.ds, port1.d};
            txn_log.push_back({port1.we, port1.a, port1.ds, port1.d});
         end
      end else begin
         moved = (port1.req !== port1.ack) && ({port1.we, port1.a, port1.ds, port1.d} !== cur);
         if (moved)
            unstable <= 1'b1;
         if (lat_left == 1) begin
            busy      <= 1'b0;
            port1.ack <= port1.req;
            if (cur.we) begin
               old = mem_rd(cur.a);
               mem[int'(cur.a)] = {cur.ds[1] ? cur.d[15:8] : old[15:8], cur.ds[0] ? cur.d[7:0] : old[7:0]};
            end else begin
               port1.q <= mem_rd(cur.a);
            end
            vectors++;
            if ((unstable || moved) !== 1'b0) begin
               miscompares++;
               $display("FAIL port1_stable: fields changed while pending, got a=%h required a=%h", port1.a, cur.a);
            end
         end else begin
            lat_left <= lat_left - 1;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (port1.req !== prev_req)
         toggles++;
      prev_req = port1.req;
      if (c0.ack === 1'b1 || c1.ack === 1'b1) begin
         if (c0.ack === 1'b1) ack_cnt[0]++;
         if (c1.ack === 1'b1) ack_cnt[1]++;
         obs.client = (c1.ack === 1'b1);
         obs.q      = obs.client ? c1.q : c0.q;
         vectors++;
         if (c0.ack === 1'b1 && c1.ack === 1'b1) begin
            miscompares++;
            $display("FAIL dual_ack: got both acks high, required one");
         end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack: got client=%0d q=%h, required no ack", obs.client, obs.q);
         end else begin
            exp_e = exp_q.pop_front();
            if (obs !== exp_e) begin
               miscompares++;
               $display("FAIL ack_data: got client=%0d q=%h, required client=%0d q=%h",
                        obs.client, obs.q, exp_e.client, exp_e.q);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_exp(input int c, input logic [15:0] q);
      q_model[c] = q;
      exp_q.push_back({c[0], q});
   endtask

   task automatic set_req(input int c, input logic we, input logic [AW:1] a,
                          input logic [1:0] ds, input logic [15:0] d);
      if (c == 0) begin
         c0.we = we; c0.a = a; c0.ds = ds; c0.d = d; c0.req = 1'b1;
      end else begin
         c1.we = we; c1.a = a; c1.ds = ds; c1.d = d; c1.req = 1'b1;
      end
   endtask

   task automatic drop_req(input int c);
      if (c == 0) c0.req = 1'b0;
      else        c1.req = 1'b0;
   endtask

   function automatic logic get_ack(input int c);
      return (c == 0) ? c0.ack : c1.ack;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      q_model[0] = '0;
      q_model[1] = '0;
   endtask

   // Hold each client's req for `hold` extra cycles after its ack, then drop it.
   task automatic run_clients(input int hold, input int budget);
      int cyc = 0;
      int hold_left [2] = '{-1, -1};
      while ((c0.req || c1.req) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         for (int c = 0; c < 2; c++) begin
            if (get_ack(c) === 1'b1) hold_left[c] = hold;
            if (hold_left[c] == 0) begin
               drop_req(c);
               hold_left[c] = -1;
            end else if (hold_left[c] > 0) begin
               hold_left[c]--;
            end
         end
      end
      if (cyc >= budget) begin
         vectors++;
         miscompares++;
         $display("FAIL run_timeout: got no ack within %0d cycles, required ack", budget);
         drop_req(0);
         drop_req(1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int t0;
      do_reset(3);
      vectors++;
      if (port1.req !== port1.ack) begin
         miscompares++;
         $display("FAIL reset_req: got req=%b ack=%b, required equal", port1.req, port1.ack);
      end
      vectors++;
      if ({port1.we, port1.a, port1.ds, port1.d} !== '0) begin
         miscompares++;
         $display("FAIL reset_port1: got we=%b a=%h ds=%b d=%h, required 0", port1.we, port1.a, port1.ds, port1.d);
      end
      vectors++;
      if ({c0.ack, c1.ack, c0.q, c1.q} !== '0) begin
         miscompares++;
         $display("FAIL reset_clients: got ack=%b%b q0=%h q1=%h, required 0", c0.ack, c1.ack, c0.q, c1.q);
      end
      t0 = toggles;
      wait_cycles(3);
      vectors++;
      if (toggles !== t0) begin
         miscompares++;
         $display("FAIL idle_toggle: got %0d toggles, required 0", toggles - t0);
      end
   endtask

   task automatic test_single_read();
      int t0, n0, a0, cyc;
      mem[32'h100] = 16'hBEEF;
      t0 = toggles; n0 = txn_log.size(); a0 = ack_cnt[0];
      push_exp(0, 16'hBEEF);
      set_req(0, 1'b0, 24'h000100, 2'b11, 16'h0);
      @(negedge clk);
      vectors++;
      if ((port1.req ^ port1.ack) !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_latency: got req=%b ack=%b, required toggled", port1.req, port1.ack);
      end
      cyc = 0;
      while (port1.ack !== port1.req && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc >= 50 || c0.ack !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_early: got ack=%b cycles=%0d, required ack=0 after completion", c0.ack, cyc);
      end
      @(negedge clk);
      vectors++;
      if (c0.ack !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_latency: got ack=%b, required 1", c0.ack);
      end
      drop_req(0);
      @(negedge clk);
      vectors++;
      if (c0.ack !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_width: got ack=%b, required 0", c0.ack);
      end
      wait_cycles(3);
      vectors++;
      if (toggles - t0 !== 1 || txn_log.size() - n0 !== 1 || ack_cnt[0] - a0 !== 1) begin
         miscompares++;
         $display("FAIL single_count: got toggles=%0d txns=%0d acks=%0d, required 1 1 1",
                  toggles - t0, txn_log.size() - n0, ack_cnt[0] - a0);
      end
      vectors++;
      if (txn_log.size() == 0 || txn_log[txn_log.size()-1].we !== 1'b0 || txn_log[txn_log.size()-1].a !== 24'h000100) begin
         miscompares++;
         $display("FAIL single_cmd: got command other than read a=000100");
      end
      vectors++;
      if (c0.q !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL single_q: got %h, required BEEF", c0.q);
      end
   endtask

   function automatic logic [AW:1] tie_addr(input int c, input int i);
      return 24'h000200 + 24'(c * 16) + 24'(i);
   endfunction

   function automatic logic [15:0] tie_data(input int c, input int i);
      return 16'hA000 + 16'(c * 16) + 16'(i);
   endfunction

   task automatic test_tie();
      int issued [2];
      int cyc, n0;
      do_reset(2);
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < 2; c++)
            mem[int'(tie_addr(c, i))] = tie_data(c, i);
      for (int k = 0; k < 6; k++)
         push_exp(k % 2, tie_data(k % 2, k / 2));
      n0 = txn_log.size();
      issued = '{1, 1};
      set_req(0, 1'b0, tie_addr(0, 0), 2'b11, 16'h0);
      set_req(1, 1'b0, tie_addr(1, 0), 2'b11, 16'h0);
      cyc = 0;
      while ((c0.req || c1.req) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         for (int c = 0; c < 2; c++) begin
            if (get_ack(c) === 1'b1) begin
               if (issued[c] < 3) begin
                  set_req(c, 1'b0, tie_addr(c, issued[c]), 2'b11, 16'h0);
                  issued[c]++;
               end else begin
                  drop_req(c);
               end
            end
         end
      end
      wait_cycles(2);
      vectors++;
      if (cyc >= 400 || txn_log.size() - n0 !== 6) begin
         miscompares++;
         $display("FAIL tie_count: got %0d transactions, required 6", txn_log.size() - n0);
      end else begin
         for (int k = 0; k < 6; k++) begin
            vectors++;
            if (txn_log[n0+k].a !== tie_addr(k % 2, k / 2)) begin
               miscompares++;
               $display("FAIL tie_order: grant %0d got a=%h, required a=%h", k, txn_log[n0+k].a, tie_addr(k % 2, k / 2));
            end
         end
      end
   endtask

   task automatic test_write();
      mem[32'h3FFFFF] = 16'hAAAA;
      push_exp(1, q_model[1]);
      set_req(1, 1'b1, 24'h3FFFFF, 2'b01, 16'h1234);
      run_clients(0, 100);
      wait_cycles(2);
      vectors++;
      if (txn_log.size() == 0 || txn_log[txn_log.size()-1] !== {1'b1, 24'h3FFFFF, 2'b01, 16'h1234}) begin
         miscompares++;
         $display("FAIL write_cmd: got we=%b a=%h ds=%b d=%h, required 1 3FFFFF 01 1234",
                  port1.we, port1.a, port1.ds, port1.d);
      end
      vectors++;
      if (c1.q !== q_model[1]) begin
         miscompares++;
         $display("FAIL write_q: got %h, required unchanged %h", c1.q, q_model[1]);
      end
      vectors++;
      if (mem_rd(24'h3FFFFF) !== 16'hAA34) begin
         miscompares++;
         $display("FAIL write_mem: got %h, required AA34", mem_rd(24'h3FFFFF));
      end
   endtask

   task automatic test_back_to_back();
      int t0, n0;
      mem[32'h40] = 16'h1111;
      mem[32'h41] = 16'h2222;
      t0 = toggles; n0 = txn_log.size();
      push_exp(0, 16'h1111);
      set_req(0, 1'b0, 24'h000040, 2'b11, 16'h0);
      run_clients(1, 100);
      wait_cycles(2);
      vectors++;
      if (txn_log.size() - n0 !== 1 || toggles - t0 !== 1) begin
         miscompares++;
         $display("FAIL hold_single: got txns=%0d toggles=%0d, required 1 1", txn_log.size() - n0, toggles - t0);
      end
      push_exp(0, 16'h2222);
      set_req(0, 1'b0, 24'h000041, 2'b11, 16'h0);
      run_clients(0, 100);
      wait_cycles(2);
      vectors++;
      if (txn_log.size() - n0 !== 2 || toggles - t0 !== 2) begin
         miscompares++;
         $display("FAIL hold_second: got txns=%0d toggles=%0d, required 2 2", txn_log.size() - n0, toggles - t0);
      end
      vectors++;
      if (c0.q !== 16'h2222) begin
         miscompares++;
         $display("FAIL hold_q: got %h, required 2222", c0.q);
      end
   endtask

   task automatic test_reset_mid();
      int a0, cyc;
      mem[32'h80] = 16'hCAFE;
      mem[32'h81] = 16'hD00D;
      a0 = ack_cnt[0];
      set_req(0, 1'b0, 24'h000080, 2'b11, 16'h0);
      cyc = 0;
      while (port1.req === port1.ack && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      wait_cycles(2);
      reset = 1'b1;
      wait_cycles(2);
      drop_req(0);
      reset = 1'b0;
      q_model[0] = '0;
      q_model[1] = '0;
      vectors++;
      if (port1.req !== port1.ack) begin
         miscompares++;
         $display("FAIL abort_req: got req=%b ack=%b, required equal", port1.req, port1.ack);
      end
      cyc = 0;
      while (busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      wait_cycles(2);
      vectors++;
      if (ack_cnt[0] - a0 !== 0 || c0.q !== 16'h0) begin
         miscompares++;
         $display("FAIL abort_ack: got acks=%0d q=%h, required 0 0000", ack_cnt[0] - a0, c0.q);
      end
      push_exp(0, 16'hD00D);
      set_req(0, 1'b0, 24'h000081, 2'b11, 16'h0);
      @(negedge clk);
      vectors++;
      if ((port1.req ^ port1.ack) !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_issue: got req=%b ack=%b, required toggled", port1.req, port1.ack);
      end
      run_clients(0, 100);
      wait_cycles(2);
      vectors++;
      if (c0.q !== 16'hD00D) begin
         miscompares++;
         $display("FAIL post_reset_q: got %h, required D00D", c0.q);
      end
   endtask

`ifdef SDRAM_ARB_RDCACHE_EN
   task automatic test_cache();
      int t0;
      mem[32'h0ABCDE] = 16'h1357;
      t0 = toggles;
      push_exp(1, 16'h1357);
      set_req(1, 1'b0, 24'h0ABCDE, 2'b11, 16'h0);
      run_clients(0, 100);
      wait_cycles(2);
      vectors++;
      if (toggles - t0 !== 1) begin
         miscompares++;
         $display("FAIL cache_fill: got %0d toggles, required 1", toggles - t0);
      end
      // Memory changes behind the cache's back: a hit must still return the cached word.
      mem[32'h0ABCDE] = 16'hFFFF;
      t0 = toggles;
      push_exp(1, 16'h1357);
      set_req(1, 1'b0, 24'h0ABCDE, 2'b11, 16'h0);
      @(negedge clk);
      vectors++;
      if (c1.ack !== 1'b0) begin
         miscompares++;
         $display("FAIL hit_early: got ack=%b, required 0", c1.ack);
      end
      @(negedge clk);
      vectors++;
      if (c1.ack !== 1'b1) begin
         miscompares++;
         $display("FAIL hit_latency: got ack=%b, required 1", c1.ack);
      end
      drop_req(1);
      wait_cycles(3);
      vectors++;
      if (toggles !== t0 || c1.q !== 16'h1357) begin
         miscompares++;
         $display("FAIL hit_toggle: got toggles=%0d q=%h, required 0 1357", toggles - t0, c1.q);
      end
      push_exp(0, q_model[0]);
      set_req(0, 1'b1, 24'h0ABCDE, 2'b11, 16'h5A5A);
      run_clients(0, 100);
      wait_cycles(2);
      t0 = toggles;
      push_exp(1, 16'h5A5A);
      set_req(1, 1'b0, 24'h0ABCDE, 2'b11, 16'h0);
      run_clients(0, 100);
      wait_cycles(2);
      vectors++;
      if (toggles - t0 !== 1 || c1.q !== 16'h5A5A) begin
         miscompares++;
         $display("FAIL cache_invalidate: got toggles=%0d q=%h, required 1 5A5A", toggles - t0, c1.q);
      end
   endtask
`else
   task automatic test_no_cache();
      int t0;
      mem[32'h0ABCDE] = 16'h1357;
      t0 = toggles;
      for (int i = 0; i < 2; i++) begin
         push_exp(1, 16'h1357);
         set_req(1, 1'b0, 24'h0ABCDE, 2'b11, 16'h0);
         run_clients(0, 100);
         wait_cycles(2);
      end
      vectors++;
      if (toggles - t0 !== 2) begin
         miscompares++;
         $display("FAIL repeat_read: got %0d toggles, required 2", toggles - t0);
      end
   endtask
`endif

   initial begin
      c0.req = 1'b0; c0.we = 1'b0; c0.a = '0; c0.ds = '0; c0.d = '0;
      c1.req = 1'b0; c1.we = 1'b0; c1.a = '0; c1.ds = '0; c1.d = '0;
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;
      test_reset();
      test_single_read();
      test_tie();
      test_write();
      test_back_to_back();
      test_reset_mid();
`ifdef SDRAM_ARB_RDCACHE_EN
      test_cache();
`else
      test_no_cache();
`endif
      wait_cycles(2);
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL missing_acks: got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion in time, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
